decode_exec_pipe: RTL and testbench
===================================

Name: decode_exec_pipe

Overview:
- Pipelined Y86 decode back-end: sits directly downstream of the register file.
- Takes raw register-file read data (valA/valB) and selects forwarded operands from the execute, memory and writeback stages.
- Latches the decoded instruction into the E pipeline register on each clock, with stall/bubble control from the hazard unit.
- Also reports load-use hazards back to the hazard unit.

Parameters:
- DATA_W, 64, operand/constant width.
- RNONE, 4'hF, register ID meaning "no register"; never matches in forwarding.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- D_stat  in  4  status from D register (1 AOK, 2 HLT, 3 ADR, 4 INS).
- D_icode, D_ifun  in  4 each  instruction code/function.
- D_valC, D_valP  in  DATA_W each  constant and next PC.
- d_srcA, d_srcB, d_dstE, d_dstM  in  4 each  decoded register IDs.
- rf_valA, rf_valB  in  DATA_W each  register-file read data for d_srcA/d_srcB.
- e_dstE, M_dstM, M_dstE, W_dstM, W_dstE  in  4 each  downstream destination IDs.
- e_valE, m_valM, M_valE, W_valM, W_valE  in  DATA_W each  matching forward values.
- E_stall, E_bubble  in  1 each  hazard-unit controls.
- E_stat, E_icode, E_ifun  out  4 each  registered.
- E_valC, E_valA, E_valB  out  DATA_W each  registered.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered.
- load_use  out  1  combinational hazard flag.
- fwd_count, bubble_count  out  32 each  statistics (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge) loads the bubble state:
  - E_stat=1, E_icode=1 (NOP), E_ifun=0.
  - E_valC/E_valA/E_valB=0.
  - E_dstE/E_dstM/E_srcA/E_srcB=RNONE.
  - Counters cleared to 0.
- Reset overrides stall and bubble, including mid-instruction.
- Priority at each posedge: reset > E_stall (hold all E regs) > E_bubble (load bubble state) > normal load.
- Simultaneous stall and bubble: stall wins.
- Normal load, 1-cycle latency: E_* <= D_*/d_* fields, plus the selected d_valA/d_valB.
- d_valA selection (combinational), first match wins:
  1. D_icode is 8 (CALL) or 7 (JXX): D_valP.
  2. d_srcA==e_dstE: e_valE.
  3. d_srcA==M_dstM: m_valM.
  4. d_srcA==M_dstE: M_valE.
  5. d_srcA==W_dstM: W_valM.
  6. d_srcA==W_dstE: W_valE.
  7. Otherwise rf_valA.
- d_valB selection: same chain on d_srcB with no valP rule; default rf_valB.
- Any source equal to RNONE never matches a forward. If d_srcA/d_srcB is RNONE, the value is rf_* as returned (0).
- The register file writes on negedge. The W-stage forward therefore always covers same-cycle writeback; rf data is never trusted over a W match.
- load_use = (E_icode==5 MRMOVQ or E_icode==4'hB POPQ) && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
- load_use is purely combinational from E regs and d_src*; it does not itself stall.
- All data paths are full DATA_W with no arithmetic; IDs are compared as 4-bit equality.

Optional Feature:
- Macro: DECODE_FWD_STATS_EN.
- When defined:
  - fwd_count increments by 1 on each normal-load posedge where d_valA or d_valB took a forward (rules 2-6). A CALL/JXX valP selection does not count.
  - bubble_count increments on each posedge that loads the bubble state due to E_bubble (reset excluded).
  - Both counters are 32-bit saturating at 32'hFFFF_FFFF, hold under stall, and clear on reset.
- When undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with E_stall=1 -> E_icode=1, E_stat=1, all E IDs=F, E_valA=0, counts=0.
- Forward priority: d_srcA=3, e_dstE=3 (e_valE=0x11), M_dstM=3 (m_valM=0x22), rf_valA=0x33 -> E_valA=0x11 next cycle. Then set e_dstE=F -> E_valA=0x22. Then set M_dstM=F, W_dstE=3 (W_valE=0x44) -> E_valA=0x44.
- CALL/JXX override: D_icode=8, D_valP=0x100, d_srcA=4, e_dstE=4 -> E_valA=0x100. The same case with D_icode=6 -> E_valA=e_valE.
- Stall/bubble: load OPQ (icode 6), then E_stall=1 with new D inputs -> E regs unchanged. Then E_stall=1 and E_bubble=1 -> unchanged. Then E_bubble=1 only -> bubble state; bubble_count=1 when the macro is enabled.
- Load-use: E_icode=5, E_dstM=2, d_srcB=2 -> load_use=1. With d_srcB=2 but E_dstM=F -> 0. With E_icode=6 and E_dstM=2 -> 0.
- RNONE: d_srcA=F, e_dstE=F, e_valE=0xDEAD, rf_valA=0 -> E_valA=0; fwd_count unchanged.

Source files
------------

// File: rtl/decode_exec_pipe_if.sv
// Decode -> E pipeline register bundle: D/d stage fields, downstream forward
// sources, hazard controls in; E register fields, load-use flag and stats out.
interface decode_exec_pipe_if #(parameter int DATA_W = 64);
  logic [3:0]        D_stat, D_icode, D_ifun;
  logic [DATA_W-1:0] D_valC, D_valP;
  logic [3:0]        d_srcA, d_srcB, d_dstE, d_dstM;
  logic [DATA_W-1:0] rf_valA, rf_valB;
  logic [3:0]        e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [DATA_W-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic              E_stall, E_bubble;
  logic [3:0]        E_stat, E_icode, E_ifun;
  logic [DATA_W-1:0] E_valC, E_valA, E_valB;
  logic [3:0]        E_dstE, E_dstM, E_srcA, E_srcB;
  logic              load_use;
  logic [31:0]       fwd_count, bubble_count;

  modport master (
    output D_stat, D_icode, D_ifun, D_valC, D_valP,
           d_srcA, d_srcB, d_dstE, d_dstM, rf_valA, rf_valB,
           e_dstE, M_dstM, M_dstE, W_dstM, W_dstE,
           e_valE, m_valM, M_valE, W_valM, W_valE,
           E_stall, E_bubble,
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, load_use, fwd_count, bubble_count
  );

  modport slave (
    input  D_stat, D_icode, D_ifun, D_valC, D_valP,
           d_srcA, d_srcB, d_dstE, d_dstM, rf_valA, rf_valB,
           e_dstE, M_dstM, M_dstE, W_dstM, W_dstE,
           e_valE, m_valM, M_valE, W_valM, W_valE,
           E_stall, E_bubble,
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB, load_use, fwd_count, bubble_count
  );
endinterface

// File: rtl/decode_exec_pipe.sv
// Y86 decode back-end: operand forwarding, E pipeline register, load-use flag.
// Define DECODE_FWD_STATS_EN to build the saturating forward/bubble counters.
module decode_exec_pipe #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input logic               clk,
  input logic               rst_n,
  decode_exec_pipe_if.slave bus
);

  typedef struct packed {
    logic [3:0]        stat, icode, ifun;
    logic [DATA_W-1:0] valC, valA, valB;
    logic [3:0]        dstE, dstM, srcA, srcB;
  } ereg_t;

  localparam ereg_t BUBBLE = '{stat: 4'd1, icode: 4'd1, ifun: 4'd0,
                               valC: '0, valA: '0, valB: '0,
                               dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

  // Forward sources in priority order, index 0 highest.
  logic [4:0][3:0]        fdst;
  logic [4:0][DATA_W-1:0] fval;
  assign fdst = {bus.W_dstE, bus.W_dstM, bus.M_dstE, bus.M_dstM, bus.e_dstE};
  assign fval = {bus.W_valE, bus.W_valM, bus.M_valE, bus.m_valM, bus.e_valE};

  function automatic logic [DATA_W-1:0] fwd_val(input logic [3:0] src,
                                                input logic [DATA_W-1:0] rf);
    logic [DATA_W-1:0] v;
    v = rf;
    for (int i = 4; i >= 0; i--)
      if (src != RNONE && fdst[i] == src) v = fval[i];
    return v;
  endfunction

  logic [DATA_W-1:0] d_valA, d_valB;
  logic              use_valp;
  assign use_valp = (bus.D_icode == 4'h8) || (bus.D_icode == 4'h7);
  assign d_valA   = use_valp ? bus.D_valP : fwd_val(bus.d_srcA, bus.rf_valA);
  assign d_valB   = fwd_val(bus.d_srcB, bus.rf_valB);

  ereg_t e_q, e_d;
  always_comb begin
    e_d = '{stat: bus.D_stat, icode: bus.D_icode, ifun: bus.D_ifun,
            valC: bus.D_valC, valA: d_valA, valB: d_valB,
            dstE: bus.d_dstE, dstM: bus.d_dstM, srcA: bus.d_srcA, srcB: bus.d_srcB};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)             e_q <= BUBBLE;
    else if (!bus.E_stall) begin
      if (bus.E_bubble)     e_q <= BUBBLE;
      else                  e_q <= e_d;
    end
  end

  assign bus.E_stat  = e_q.stat;
  assign bus.E_icode = e_q.icode;
  assign bus.E_ifun  = e_q.ifun;
  assign bus.E_valC  = e_q.valC;
  assign bus.E_valA  = e_q.valA;
  assign bus.E_valB  = e_q.valB;
  assign bus.E_dstE  = e_q.dstE;
  assign bus.E_dstM  = e_q.dstM;
  assign bus.E_srcA  = e_q.srcA;
  assign bus.E_srcB  = e_q.srcB;

  // Only loads and pops produce a value late enough to need a stall.
  assign bus.load_use = ((e_q.icode == 4'h5) || (e_q.icode == 4'hB)) &&
                        (e_q.dstM != RNONE) &&
                        ((e_q.dstM == bus.d_srcA) || (e_q.dstM == bus.d_srcB));

`ifdef DECODE_FWD_STATS_EN
  function automatic logic fwd_hit(input logic [3:0] src);
    logic h;
    h = 1'b0;
    for (int i = 0; i < 5; i++)
      if (src != RNONE && fdst[i] == src) h = 1'b1;
    return h;
  endfunction

  logic        any_fwd;
  logic [31:0] fwd_cnt, bub_cnt;
  // valP selection on CALL/JXX is not a forward, so srcA hits are masked there.
  assign any_fwd = (!use_valp && fwd_hit(bus.d_srcA)) || fwd_hit(bus.d_srcB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_cnt <= '0;
      bub_cnt <= '0;
    end else if (!bus.E_stall) begin
      if (bus.E_bubble) begin
        if (bub_cnt != '1) bub_cnt <= bub_cnt + 32'd1;
      end else if (any_fwd && fwd_cnt != '1) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end

  assign bus.fwd_count    = fwd_cnt;
  assign bus.bubble_count = bub_cnt;
`else
  assign bus.fwd_count    = 32'd0;
  assign bus.bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_decode_exec_pipe.sv
// Randomized + directed bench for decode_exec_pipe against a behavioural model
// of the E register, forwarding rules, load-use flag and statistics counters.
module tb_decode_exec_pipe;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_exec_pipe_if #(.DATA_W(W)) bus ();
  decode_exec_pipe #(.DATA_W(W), .RNONE(4'hF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0]   stat, icode, ifun;
    logic [W-1:0] valC, valA, valB;
    logic [3:0]   dstE, dstM, srcA, srcB;
  } mreg_t;

  mreg_t       m;
  bit          m_valid = 0;
  int unsigned m_fwd, m_bub;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic mreg_t bubble_state();
    mreg_t b;
    b.stat = 1; b.icode = 1; b.ifun = 0;
    b.valC = 0; b.valA = 0; b.valB = 0;
    b.dstE = 4'hF; b.dstM = 4'hF; b.srcA = 4'hF; b.srcB = 4'hF;
    return b;
  endfunction

  // Reference forward: scan the stage list youngest-first, first match wins.
  function automatic logic [W-1:0] ref_fwd(input logic [3:0] src, input logic [W-1:0] rf,
                                           output bit hit);
    logic [3:0]   ids [5];
    logic [W-1:0] vals[5];
    ids  = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    hit = 0;
    if (src == 4'hF) return rf;
    foreach (ids[k]) if (ids[k] == src) begin hit = 1; return vals[k]; end
    return rf;
  endfunction

  task automatic set_defaults();
    bus.D_stat = 1; bus.D_icode = 6; bus.D_ifun = 0; bus.D_valC = 0; bus.D_valP = 0;
    bus.d_srcA = 4'hF; bus.d_srcB = 4'hF; bus.d_dstE = 4'hF; bus.d_dstM = 4'hF;
    bus.rf_valA = 0; bus.rf_valB = 0;
    bus.e_dstE = 4'hF; bus.M_dstM = 4'hF; bus.M_dstE = 4'hF; bus.W_dstM = 4'hF; bus.W_dstE = 4'hF;
    bus.e_valE = 0; bus.m_valM = 0; bus.M_valE = 0; bus.W_valM = 0; bus.W_valE = 0;
    bus.E_stall = 0; bus.E_bubble = 0;
  endtask

  function automatic logic [3:0] rid();
    return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
  endfunction

  function automatic logic [W-1:0] rval();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_inputs();
    bus.D_stat = 4'($urandom_range(1, 4)); bus.D_icode = 4'($urandom_range(0, 11));
    bus.D_ifun = 4'($urandom); bus.D_valC = rval(); bus.D_valP = rval();
    bus.d_srcA = rid(); bus.d_srcB = rid(); bus.d_dstE = rid(); bus.d_dstM = rid();
    bus.rf_valA = rval(); bus.rf_valB = rval();
    bus.e_dstE = rid(); bus.M_dstM = rid(); bus.M_dstE = rid(); bus.W_dstM = rid(); bus.W_dstE = rid();
    bus.e_valE = rval(); bus.m_valM = rval(); bus.M_valE = rval(); bus.W_valM = rval(); bus.W_valE = rval();
    bus.E_stall  = ($urandom_range(0, 7) == 0);
    bus.E_bubble = ($urandom_range(0, 5) == 0);
    rst_n = ($urandom_range(0, 60) != 0);
  endtask

  // One clock: check load_use on current state, predict next E, compare after edge.
  task automatic tick();
    bit ha, hb, lu;
    logic [W-1:0] va, vb;
    #1;
    if (m_valid) begin
      lu = (m.icode == 5 || m.icode == 11) && m.dstM != 4'hF &&
           (m.dstM == bus.d_srcA || m.dstM == bus.d_srcB);
      chk("load_use", W'(bus.load_use), W'(lu));
    end
    va = ref_fwd(bus.d_srcA, bus.rf_valA, ha);
    vb = ref_fwd(bus.d_srcB, bus.rf_valB, hb);
    if (bus.D_icode == 7 || bus.D_icode == 8) begin va = bus.D_valP; ha = 0; end
    if (!rst_n) begin
      m = bubble_state(); m_fwd = 0; m_bub = 0; m_valid = 1;
    end else if (bus.E_stall) begin
    end else if (bus.E_bubble) begin
      m = bubble_state();
      if (m_bub != 32'hFFFF_FFFF) m_bub++;
    end else begin
      m.stat = bus.D_stat; m.icode = bus.D_icode; m.ifun = bus.D_ifun;
      m.valC = bus.D_valC; m.valA = va; m.valB = vb;
      m.dstE = bus.d_dstE; m.dstM = bus.d_dstM; m.srcA = bus.d_srcA; m.srcB = bus.d_srcB;
      if ((ha || hb) && m_fwd != 32'hFFFF_FFFF) m_fwd++;
    end
    @(posedge clk);
    #1;
    chk("E_stat", W'(bus.E_stat), W'(m.stat));
    chk("E_icode", W'(bus.E_icode), W'(m.icode));
    chk("E_ifun", W'(bus.E_ifun), W'(m.ifun));
    chk("E_valC", bus.E_valC, m.valC);
    chk("E_valA", bus.E_valA, m.valA);
    chk("E_valB", bus.E_valB, m.valB);
    chk("E_ids", W'({bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB}),
        W'({m.dstE, m.dstM, m.srcA, m.srcB}));
`ifdef DECODE_FWD_STATS_EN
    chk("fwd_count", W'(bus.fwd_count), W'(m_fwd));
    chk("bubble_count", W'(bus.bubble_count), W'(m_bub));
`else
    chk("fwd_count", W'(bus.fwd_count), 0);
    chk("bubble_count", W'(bus.bubble_count), 0);
`endif
  endtask

  initial begin
    logic [31:0] fc;
    set_defaults();
    rst_n = 0;
    bus.E_stall = 1;
    tick(); tick();
    chk("rst_icode", W'(bus.E_icode), 1);
    chk("rst_valA", bus.E_valA, 0);
    chk("rst_ids", W'({bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB}), W'(16'hFFFF));
    rst_n = 1; set_defaults();

    // Forward priority chain
    bus.d_srcA = 3; bus.e_dstE = 3; bus.e_valE = 'h11; bus.M_dstM = 3; bus.m_valM = 'h22;
    bus.rf_valA = 'h33;
    tick(); chk("fwd_e", bus.E_valA, 'h11);
    bus.e_dstE = 4'hF;
    tick(); chk("fwd_m", bus.E_valA, 'h22);
    bus.M_dstM = 4'hF; bus.W_dstE = 3; bus.W_valE = 'h44;
    tick(); chk("fwd_w", bus.E_valA, 'h44);

    // CALL/JXX valP override
    set_defaults();
    bus.D_icode = 8; bus.D_valP = 'h100; bus.d_srcA = 4; bus.e_dstE = 4; bus.e_valE = 'h55;
    tick(); chk("call_valp", bus.E_valA, 'h100);
    bus.D_icode = 7;
    tick(); chk("jxx_valp", bus.E_valA, 'h100);
    bus.D_icode = 6;
    tick(); chk("opq_fwd", bus.E_valA, 'h55);

    // Stall / bubble priority
    set_defaults(); bus.D_valC = 'hAA;
    tick();
    bus.E_stall = 1; bus.D_icode = 2; bus.D_valC = 'hBB;
    tick(); chk("stall_hold", bus.E_valC, 'hAA);
    bus.E_bubble = 1;
    tick(); chk("stall_over_bubble", W'(bus.E_icode), 6);
    bus.E_stall = 0;
    tick(); chk("bubble_icode", W'(bus.E_icode), 1);
`ifdef DECODE_FWD_STATS_EN
    chk("bubble_cnt1", W'(bus.bubble_count), 1);
`endif

    // Load-use
    set_defaults(); bus.D_icode = 5; bus.d_dstM = 2;
    tick();
    bus.D_icode = 6; bus.d_dstM = 4'hF; bus.d_srcB = 2; #1;
    chk("lu_hit", W'(bus.load_use), 1);
    bus.D_icode = 5; bus.d_dstM = 4'hF;
    tick(); #1;
    chk("lu_rnone", W'(bus.load_use), 0);
    bus.D_icode = 6; bus.d_dstM = 2;
    tick(); #1;
    chk("lu_opq", W'(bus.load_use), 0);

    // RNONE never forwards
    set_defaults(); bus.e_valE = 'hDEAD;
    fc = bus.fwd_count;
    tick();
    chk("rnone_valA", bus.E_valA, 0);
    chk("rnone_fwdcnt", W'(bus.fwd_count), W'(fc));

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
